// File: rtl/relu_backward_unit.sv
// Backward ReLU gradient gate: forward samples push a positivity mask bit into a FIFO, and
// backward gradients pop it, passing the gradient (mask=1) or zero through a 1-deep output register.
module relu_backward_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     fwd_valid,
  output logic                     fwd_ready,
  input  logic signed [DATA_W-1:0] fwd_data,
  input  logic                     bwd_valid,
  output logic                     bwd_ready,
  input  logic signed [DATA_W-1:0] bwd_grad,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_grad,
  output logic [$clog2(DEPTH):0]   mask_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Signed compare: zero and every negative value (including the most negative) give 0.
  function automatic logic relu_mask(input logic signed [DATA_W-1:0] v);
    return v > $signed({DATA_W{1'b0}});
  endfunction

  logic                     mask_mem_q [DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_grad_q, out_grad_d;
  logic                     push, pop, pop_mask, mask_wr;

  assign fwd_ready  = count_q < FULL_CNT;
  assign bwd_ready  = (count_q != '0) && (!out_valid_q || out_ready);
  assign push       = fwd_valid && fwd_ready && !clear;
  assign pop        = bwd_valid && bwd_ready && !clear;
  assign pop_mask   = mask_mem_q[rd_ptr_q];
  assign mask_wr    = relu_mask(fwd_data);
  assign out_valid  = out_valid_q;
  assign out_grad   = out_grad_q;
  assign mask_count = count_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_grad_d  = out_grad_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // A new pop reloads the register; otherwise an accepted word empties it.
      if (pop) begin
        out_valid_d = 1'b1;
        out_grad_d  = pop_mask ? bwd_grad : '0;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_grad_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_grad_q  <= out_grad_d;
    end
  end

  // Mask storage is only read behind the count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mask_mem_q[wr_ptr_q] <= mask_wr;
  end

endmodule

// File: tb/tb_relu_backward_unit.sv
// Self-checking bench for relu_backward_unit: scripted scenarios plus a scoreboard that
// predicts every gated gradient from a queue-based mask model.
module tb_relu_backward_unit;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              fwd_valid = 1'b0;
  logic              bwd_valid = 1'b0;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] fwd_data = '0;
  logic [DATA_W-1:0] bwd_grad = '0;
  logic              fwd_ready, bwd_ready, out_valid;
  logic [DATA_W-1:0] out_grad;
  logic [6:0]        mask_count;

  int checks = 0;
  int errors = 0;

  bit                mq[$];
  logic [DATA_W-1:0] exp_q[$];
  logic              mon_m;
  logic [DATA_W-1:0] mon_e;

  relu_backward_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
    .bwd_valid(bwd_valid), .bwd_ready(bwd_ready), .bwd_grad(bwd_grad),
    .out_valid(out_valid), .out_ready(out_ready), .out_grad(out_grad),
    .mask_count(mask_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: handshakes sampled on the falling edge, ahead of the rising edge that commits them.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      exp_q.delete();
    end else begin
      checks++;
      if (mask_count !== 7'(mq.size())) begin
        errors++; $display("FAIL sb_mask_count: got %0d want %0d", mask_count, mq.size());
      end
      checks++;
      if (fwd_ready !== (mq.size() < DEPTH)) begin
        errors++; $display("FAIL sb_fwd_ready: got %b want %b", fwd_ready, mq.size() < DEPTH);
      end
      checks++;
      if (bwd_ready !== (mq.size() != 0 && (exp_q.size() == 0 || out_ready))) begin
        errors++; $display("FAIL sb_bwd_ready: got %b want %b", bwd_ready,
                           mq.size() != 0 && (exp_q.size() == 0 || out_ready));
      end
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL sb_out_valid: got %b want %b", out_valid, exp_q.size() != 0);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL sb_out_grad: got %h want no output", out_grad);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_grad !== mon_e) begin
            errors++; $display("FAIL sb_out_grad: got %h want %h", out_grad, mon_e);
          end
        end
      end
      if (clear) begin
        mq.delete();
        exp_q.delete();
      end else begin
        if (bwd_valid && bwd_ready && mq.size() != 0) begin
          mon_m = mq.pop_front();
          exp_q.push_back(mon_m ? bwd_grad : '0);
        end
        if (fwd_valid && fwd_ready) mq.push_back(!fwd_data[DATA_W-1] && (fwd_data != '0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rand_pre();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic push_word(input logic [DATA_W-1:0] d);
    int n = 0;
    fwd_valid = 1'b1;
    fwd_data  = d;
    while (!fwd_ready && n < 100) begin
      step();
      n++;
    end
    if (!fwd_ready) begin
      errors++; $display("FAIL push_timeout: fwd_ready got 0 want 1 within 100 cycles");
    end
    step();
    fwd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (mask_count != 0 && n < 300) begin
      bwd_valid = 1'b1;
      bwd_grad  = $urandom;
      step();
      n++;
    end
    bwd_valid = 1'b0;
    step();
    step();
    checks++;
    if (mask_count !== 7'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty: count %0d valid %b want 0 0", mask_count, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_grad !== '0) begin errors++; $display("FAIL reset_out_grad: got %h want 0", out_grad); end
    checks++; if (fwd_ready !== 1'b1) begin errors++; $display("FAIL reset_fwd_ready: got %b want 1", fwd_ready); end
    checks++; if (bwd_ready !== 1'b0) begin errors++; $display("FAIL reset_bwd_ready: got %b want 0", bwd_ready); end
    checks++; if (mask_count !== 7'd0) begin errors++; $display("FAIL reset_mask_count: got %0d want 0", mask_count); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_mask_order();
    logic [DATA_W-1:0] pre  [4] = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [DATA_W-1:0] grd  [4] = '{32'd10, 32'd20, 32'd30, 32'd40};
    logic [DATA_W-1:0] want [4] = '{32'd10, 32'd0, 32'd0, 32'd40};
    for (int i = 0; i < 4; i++) push_word(pre[i]);
    checks++; if (mask_count !== 7'd4) begin errors++; $display("FAIL order_count: got %0d want 4", mask_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bwd_valid = 1'b1;
      bwd_grad  = grd[i];
      step();
      checks++;
      if (out_valid !== 1'b1 || out_grad !== want[i]) begin
        errors++; $display("FAIL order_out%0d: valid %b grad %0d want 1 %0d", i, out_valid, out_grad, want[i]);
      end
      checks++;
      if (mask_count !== 7'(3 - i)) begin
        errors++; $display("FAIL order_count%0d: got %0d want %0d", i, mask_count, 3 - i);
      end
    end
    bwd_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL order_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_full();
    fwd_valid = 1'b1;
    fwd_data  = 32'd1;
    repeat (DEPTH) step();
    checks++; if (mask_count !== 7'd64) begin errors++; $display("FAIL full_count: got %0d want 64", mask_count); end
    checks++; if (fwd_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", fwd_ready); end
    step();
    checks++; if (mask_count !== 7'd64) begin errors++; $display("FAIL full_held: got %0d want 64", mask_count); end
    bwd_valid = 1'b1;
    bwd_grad  = $urandom;
    step();
    bwd_valid = 1'b0;
    checks++; if (fwd_ready !== 1'b1) begin errors++; $display("FAIL full_reopen: got %b want 1", fwd_ready); end
    checks++; if (mask_count !== 7'd63) begin errors++; $display("FAIL full_pop_count: got %0d want 63", mask_count); end
    step();
    checks++; if (mask_count !== 7'd64) begin errors++; $display("FAIL full_refill: got %0d want 64", mask_count); end
    fwd_valid = 1'b0;
    drain();
  endtask

  task automatic test_backpressure();
    push_word(32'd3);
    push_word(32'd4);
    out_ready = 1'b0;
    bwd_valid = 1'b1;
    bwd_grad  = 32'd7;
    step();
    bwd_grad  = 32'd9;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_grad !== 32'd7) begin
        errors++; $display("FAIL bp_hold%0d: valid %b grad %0d want 1 7", i, out_valid, out_grad);
      end
      checks++; if (bwd_ready !== 1'b0) begin errors++; $display("FAIL bp_bwd_ready%0d: got %b want 0", i, bwd_ready); end
      checks++; if (mask_count !== 7'd1) begin errors++; $display("FAIL bp_count%0d: got %0d want 1", i, mask_count); end
      step();
    end
    out_ready = 1'b1;
    step();
    bwd_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_grad !== 32'd9) begin
      errors++; $display("FAIL bp_second: valid %b grad %0d want 1 9", out_valid, out_grad);
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) push_word(rand_pre());
    out_ready = 1'b1;
    fwd_valid = 1'b1;
    bwd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      fwd_data = rand_pre();
      bwd_grad = $urandom;
      step();
      checks++;
      if (mask_count !== 7'd3) begin errors++; $display("FAIL stream_count%0d: got %0d want 3", i, mask_count); end
    end
    fwd_valid = 1'b0;
    bwd_valid = 1'b0;
    step();
    drain();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 11; i++) push_word(rand_pre());
    out_ready = 1'b0;
    bwd_valid = 1'b1;
    bwd_grad  = $urandom;
    step();
    bwd_valid = 1'b0;
    checks++; if (mask_count !== 7'd10) begin errors++; $display("FAIL clr_pre_count: got %0d want 10", mask_count); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_pre_valid: got %b want 1", out_valid); end
    clear     = 1'b1;
    fwd_valid = 1'b1;
    fwd_data  = 32'd1;
    bwd_valid = 1'b1;
    step();
    clear     = 1'b0;
    fwd_valid = 1'b0;
    bwd_valid = 1'b0;
    checks++; if (mask_count !== 7'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", mask_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", out_valid); end
    checks++; if (bwd_ready !== 1'b0) begin errors++; $display("FAIL clr_bwd_ready: got %b want 0", bwd_ready); end
    checks++; if (fwd_ready !== 1'b1) begin errors++; $display("FAIL clr_fwd_ready: got %b want 1", fwd_ready); end
    out_ready = 1'b1;
    push_word(32'd2);
    push_word(32'hFFFF_FFFE);
    push_word(32'd6);
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) push_word(32'd1);
    out_ready = 1'b0;
    bwd_valid = 1'b1;
    bwd_grad  = 32'd55;
    step();
    bwd_valid = 1'b0;
    checks++; if (mask_count !== 7'd5) begin errors++; $display("FAIL ar_pre_count: got %0d want 5", mask_count); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b want 1", out_valid); end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (mask_count !== 7'd0) begin errors++; $display("FAIL ar_count: got %0d want 0", mask_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", out_valid); end
    checks++; if (out_grad !== '0) begin errors++; $display("FAIL ar_grad: got %h want 0", out_grad); end
    checks++; if (fwd_ready !== 1'b1) begin errors++; $display("FAIL ar_fwd_ready: got %b want 1", fwd_ready); end
    checks++; if (bwd_ready !== 1'b0) begin errors++; $display("FAIL ar_bwd_ready: got %b want 0", bwd_ready); end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    push_word(32'd5);
    bwd_valid = 1'b1;
    bwd_grad  = 32'd77;
    step();
    bwd_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_grad !== 32'd77) begin
      errors++; $display("FAIL ar_after: valid %b grad %0d want 1 77", out_valid, out_grad);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_mask_order();
    test_full();
    test_backpressure();
    test_stream();
    test_clear();
    test_async_reset();
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL final_pending: got %0d outstanding want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
